// File: rtl/mips_cpu_regfile_p_if.sv
// Register-file bus: two read ports with pending flags, one write port,
// a load-issue mark port and the clear-sweep request/status pair.
interface mips_cpu_regfile_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read_r1;
  logic [ADDR_W-1:0] read_r2;
  logic [DATA_W-1:0] data_r1;
  logic [DATA_W-1:0] data_r2;
  logic              pending_r1;
  logic              pending_r2;
  logic              write_enable;
  logic [ADDR_W-1:0] write_r;
  logic [DATA_W-1:0] write_data;
  logic              mark_enable;
  logic [ADDR_W-1:0] mark_r;
  logic              clear_req;
  logic              busy;

  // Pipeline side: issues reads, writes, marks and clear requests.
  modport master (
    output read_r1, read_r2, write_enable, write_r, write_data,
           mark_enable, mark_r, clear_req,
    input  data_r1, data_r2, pending_r1, pending_r2, busy
  );

  // Register-file side.
  modport slave (
    input  read_r1, read_r2, write_enable, write_r, write_data,
           mark_enable, mark_r, clear_req,
    output data_r1, data_r2, pending_r1, pending_r2, busy
  );
endinterface

// File: rtl/mips_cpu_regfile_p.sv
// MIPS register file with combinational reads, optional write-to-read
// forwarding, per-register load-pending flags and a one-entry-per-cycle
// clear sweep. Register 0 is hardwired to zero.
module mips_cpu_regfile_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mips_cpu_regfile_p_if.slave  rf
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              busy;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic wr_en;
  logic mk_en;
  logic hit1;
  logic hit2;

  // Writes and marks are dropped while sweeping and never touch r0.
  assign wr_en = rf.write_enable && !busy && (rf.write_r != '0);
  assign mk_en = rf.mark_enable  && !busy && (rf.mark_r  != '0);

  // Same-cycle forwarding only exists when BYPASS is enabled.
  assign hit1 = (BYPASS != 0) && wr_en && (rf.write_r == rf.read_r1);
  assign hit2 = (BYPASS != 0) && wr_en && (rf.write_r == rf.read_r2);

  // State register for the clear sweep.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: start on a request, finish after the last address.
  // NOTE: default assignment first so no path leaves state_nxt unassigned
  // and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rf.clear_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: busy is simply "in CLEAR".
  always_comb begin
    busy = (state == CLEAR);
  end

  // Sweep counter: parked at 0 in IDLE so every sweep starts at address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  // Array and pending flags: sweep, or write then mark so a same-cycle
  // mark to the written register leaves the flag set.
  // NOTE: the array is reset because the reset must clear every register
  // without a clock; this keeps it as flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else if (busy) begin
      mem[cnt]  <= '0;
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[rf.write_r]  <= rf.write_data;
        pend[rf.write_r] <= 1'b0;
      end
      if (mk_en) pend[rf.mark_r] <= 1'b1;
    end
  end

  // Read ports: zero under reset and for r0, forwarded data on a hit.
  always_comb begin
    rf.data_r1    = '0;
    rf.data_r2    = '0;
    rf.pending_r1 = 1'b0;
    rf.pending_r2 = 1'b0;
    if (reset_n) begin
      if (rf.read_r1 != '0) begin
        rf.data_r1    = hit1 ? rf.write_data : mem[rf.read_r1];
        rf.pending_r1 = !hit1 && pend[rf.read_r1];
      end
      if (rf.read_r2 != '0) begin
        rf.data_r2    = hit2 ? rf.write_data : mem[rf.read_r2];
        rf.pending_r2 = !hit2 && pend[rf.read_r2];
      end
    end
  end

  assign rf.busy = busy;

endmodule
